// File: rtl/smachine_selftest_pkg.sv
// Shared types and constants for the S-Machine self-test sequencer.
//   state_t     : sequencer state encoding (IDLE..DONE)
//   SYNC_STAGES : depth of the LED input synchroniser
package smachine_selftest_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_QUIESCE = 3'd1,
        ST_APPLY   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_NEXT    = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/smachine_sync2.sv
// Parametrised-width multi-flop synchroniser (SYNC_STAGES deep, 2 by default)
// with asynchronous active-low reset.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears every stage
//   d     : asynchronous input vector
//   q     : synchronised output, lags d by SYNC_STAGES cycles
module smachine_sync2
    import smachine_selftest_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_r [SYNC_STAGES];

    // Shift the input through the synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            stage_r[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign q = stage_r[SYNC_STAGES-1];

endmodule

// File: rtl/smachine_selftest_seq.sv
// On-board self-test sequencer for the S-Machine CPU. After a start request it
// holds the CPU disabled and checks that the LEDs are dark, then walks an
// external step table: each step drives a switch value, enables the CPU and
// waits (bounded by TIMEOUT) for the masked LEDs to match the expected value.
//
// Ports:
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   start, abort      : start request (ignored while busy), synchronous abort
//   dut_enable/dut_sw : registered CPU enable and switch drive
//   dut_led           : CPU LED outputs (asynchronous, synchronised inside)
//   step_idx          : step table address; table answers in the same cycle
//   step_sw/exp/mask  : table data for the addressed step
//   busy, done, pass  : progress / completion / verdict (pass valid with done)
//   quiesce_fail      : LEDs were lit while the CPU was disabled
//   fail_step         : first failing step index
//   fail_cnt          : failed-step count (only with SELFTEST_CONTINUE_EN)
//
// Build option: define SELFTEST_CONTINUE_EN to keep running after a step
// timeout and count failures instead of stopping at the first one.
module smachine_selftest_seq
    import smachine_selftest_pkg::*;
#(
    parameter int NUM_SW      = 2,
    parameter int NUM_LED     = 2,
    parameter int NUM_STEPS   = 16,
    parameter int HOLD_CYCLES = 2,
    parameter int TIMEOUT     = 200,
    parameter int IDX_W       = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    output logic               dut_enable,
    output logic [NUM_SW-1:0]  dut_sw,
    input  logic [NUM_LED-1:0] dut_led,
    output logic [IDX_W-1:0]   step_idx,
    input  logic [NUM_SW-1:0]  step_sw,
    input  logic [NUM_LED-1:0] step_exp,
    input  logic [NUM_LED-1:0] step_mask,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               quiesce_fail,
    output logic [IDX_W-1:0]   fail_step
`ifdef SELFTEST_CONTINUE_EN
    ,
    output logic [IDX_W:0]     fail_cnt
`endif
);

    localparam int TMR_W  = $clog2(TIMEOUT + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_STEPS - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
    localparam logic [TMR_W-1:0]  TMR_LOAD  = TMR_W'(TIMEOUT);
    localparam logic [TMR_W-1:0]  TMR_ONE   = TMR_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
`ifdef SELFTEST_CONTINUE_EN
    localparam logic [IDX_W:0]    CNT_MAX   = (IDX_W+1)'(NUM_STEPS);
    localparam logic [IDX_W:0]    CNT_ONE   = (IDX_W+1)'(1);
`endif

    state_t              state_r;
    logic [HOLD_W-1:0]   hold_cnt_r;
    logic [TMR_W-1:0]    timer_r;
    logic [NUM_LED-1:0]  led_s;
    logic                match_s;
    logic                in_run_s;

    smachine_sync2 #(.WIDTH(NUM_LED)) u_led_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (dut_led),
        .q     (led_s)
    );

    // Only bits selected by the mask take part in the compare.
    assign match_s  = (((led_s ^ step_exp) & step_mask) == {NUM_LED{1'b0}});
    assign in_run_s = (state_r != ST_IDLE) && (state_r != ST_DONE);

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            hold_cnt_r   <= {HOLD_W{1'b0}};
            timer_r      <= {TMR_W{1'b0}};
            dut_enable   <= 1'b0;
            dut_sw       <= {NUM_SW{1'b0}};
            step_idx     <= {IDX_W{1'b0}};
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            quiesce_fail <= 1'b0;
            fail_step    <= {IDX_W{1'b0}};
`ifdef SELFTEST_CONTINUE_EN
            fail_cnt     <= {(IDX_W+1){1'b0}};
`endif
        end else if (abort && in_run_s) begin
            state_r    <= ST_IDLE;
            dut_enable <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    // abort has priority over a simultaneous start
                    if (start && !abort) begin
                        state_r      <= ST_QUIESCE;
                        hold_cnt_r   <= HOLD_LOAD;
                        dut_enable   <= 1'b0;
                        dut_sw       <= {NUM_SW{1'b0}};
                        step_idx     <= {IDX_W{1'b0}};
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        pass         <= 1'b0;
                        quiesce_fail <= 1'b0;
                        fail_step    <= {IDX_W{1'b0}};
`ifdef SELFTEST_CONTINUE_EN
                        fail_cnt     <= {(IDX_W+1){1'b0}};
`endif
                    end
                end
                ST_QUIESCE: begin
                    if (led_s != {NUM_LED{1'b0}}) begin
                        quiesce_fail <= 1'b1;
                        pass         <= 1'b0;
                        done         <= 1'b1;
                        busy         <= 1'b0;
                        state_r      <= ST_DONE;
                    end else if (hold_cnt_r == HOLD_ONE) begin
                        state_r <= ST_APPLY;
                    end else begin
                        hold_cnt_r <= hold_cnt_r - HOLD_ONE;
                    end
                end
                ST_APPLY: begin
                    dut_sw     <= step_sw;
                    dut_enable <= 1'b1;
                    timer_r    <= TMR_LOAD;
                    state_r    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // a match in the last timer cycle still counts as a match
                    if (match_s) begin
                        state_r <= ST_NEXT;
                    end else if (timer_r == TMR_ONE) begin
`ifdef SELFTEST_CONTINUE_EN
                        if (fail_cnt == {(IDX_W+1){1'b0}}) begin
                            fail_step <= step_idx;
                        end
                        if (fail_cnt != CNT_MAX) begin
                            fail_cnt <= fail_cnt + CNT_ONE;
                        end
                        state_r <= ST_NEXT;
`else
                        fail_step  <= step_idx;
                        pass       <= 1'b0;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        dut_enable <= 1'b0;
                        state_r    <= ST_DONE;
`endif
                    end else begin
                        timer_r <= timer_r - TMR_ONE;
                    end
                end
                ST_NEXT: begin
                    if (step_idx == LAST_IDX) begin
`ifdef SELFTEST_CONTINUE_EN
                        pass <= (fail_cnt == {(IDX_W+1){1'b0}}) && !quiesce_fail;
`else
                        // any failure would already have ended the run
                        pass <= !quiesce_fail;
`endif
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        dut_enable <= 1'b0;
                        state_r    <= ST_DONE;
                    end else begin
                        step_idx <= step_idx + IDX_ONE;
                        state_r  <= ST_APPLY;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    dut_enable <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_smachine_selftest_seq.sv
// Self-checking bench for smachine_selftest_seq: directed scenario table,
// randomized step tables scored against a step-level timeline model, and
// hand-written reset/abort sequences.
module tb_smachine_selftest_seq;

    localparam int NST  = 16;
    localparam int HOLD = 2;
    localparam int TMO  = 200;
    localparam int IW   = 4;
    localparam int OFF  = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          dut_enable;
    logic [1:0]    dut_sw;
    logic [1:0]    dut_led;
    logic [IW-1:0] step_idx;
    logic [1:0]    step_sw, step_exp, step_mask;
    logic          busy, done, pass, quiesce_fail;
    logic [IW-1:0] fail_step;
`ifdef SELFTEST_CONTINUE_EN
    logic [IW:0]   fail_cnt;
`endif

    smachine_selftest_seq #(
        .NUM_SW(2), .NUM_LED(2), .NUM_STEPS(NST), .HOLD_CYCLES(HOLD), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .dut_enable(dut_enable), .dut_sw(dut_sw), .dut_led(dut_led),
        .step_idx(step_idx), .step_sw(step_sw), .step_exp(step_exp), .step_mask(step_mask),
        .busy(busy), .done(done), .pass(pass), .quiesce_fail(quiesce_fail),
        .fail_step(fail_step)
`ifdef SELFTEST_CONTINUE_EN
        , .fail_cnt(fail_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Step table and CPU model state
    logic [1:0] cur_sw [NST];
    logic [1:0] cur_exp [NST];
    logic [1:0] cur_mask [NST];
    int         cur_delay = 0;
    bit         force_on = 1'b0;
    logic [1:0] force_val = 2'b00;
    logic [1:0] hist [8];

    assign step_sw   = cur_sw[step_idx];
    assign step_exp  = cur_exp[step_idx];
    assign step_mask = cur_mask[step_idx];

    // CPU model: LEDs echo the switches, delayed, while enabled
    always @(posedge clk) begin
        hist[0] <= dut_enable ? dut_sw : 2'b00;
        for (int i = 1; i < 8; i++) hist[i] <= hist[i-1];
    end

    always_comb begin
        if (force_on)            dut_led = force_val;
        else if (cur_delay == 0) dut_led = dut_enable ? dut_sw : 2'b00;
        else                     dut_led = hist[cur_delay-1];
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: step-level timeline of what the CPU shows
    logic [1:0] tl_sw [8192];
    bit         tl_en [8192];
    int         m_done_c, m_fail_step, m_fail_cnt, m_first;
    bit         m_pass, m_qfail;
    logic [1:0] m_last_sw;

    function automatic logic [1:0] lit_at(input int c);
        int i;
        i = c + OFF;
        if (i < 0) return 2'b00;
        return tl_en[i] ? tl_sw[i] : 2'b00;
    endfunction

    // Cycle 0 is the first cycle after start is taken; LEDs seen by the
    // sequencer in cycle c are what the CPU showed in cycle c-2-delay.
    task automatic model_run();
        int c;
        logic [1:0] prev_sw, view;
        bit prev_en, matched;
        for (int i = 0; i < 8192; i++) begin
            tl_sw[i] = 2'b00;
            tl_en[i] = 1'b0;
        end
        m_fail_cnt = 0; m_first = -1; m_qfail = 1'b0; m_last_sw = 2'b00;
        if (force_on && force_val != 2'b00) begin
            m_qfail = 1'b1; m_pass = 1'b0; m_done_c = 1; m_fail_step = 0;
            return;
        end
        c = HOLD; prev_sw = 2'b00; prev_en = 1'b0;
        for (int k = 0; k < NST; k++) begin
            tl_sw[c+OFF] = prev_sw; tl_en[c+OFF] = prev_en; c++;
            matched = 1'b0;
            for (int j = 0; j < TMO && !matched; j++) begin
                tl_sw[c+OFF] = cur_sw[k]; tl_en[c+OFF] = 1'b1;
                view = lit_at(c - 2 - cur_delay);
                matched = (((view ^ cur_exp[k]) & cur_mask[k]) == 2'b00);
                c++;
            end
            prev_sw = cur_sw[k]; prev_en = 1'b1; m_last_sw = cur_sw[k];
            if (!matched) begin
                m_fail_cnt++;
                if (m_first < 0) m_first = k;
`ifndef SELFTEST_CONTINUE_EN
                m_done_c = c; m_pass = 1'b0; m_fail_step = k;
                return;
`endif
            end
            tl_sw[c+OFF] = cur_sw[k]; tl_en[c+OFF] = 1'b1; c++;
        end
        m_done_c = c;
        m_pass = (m_fail_cnt == 0);
        m_fail_step = (m_first < 0) ? 0 : m_first;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Start one run and score it; a start pulse at cycle 5 must be ignored.
    task automatic do_run(input string tag, input bit exp_pass, input bit exp_qf,
                          input int exp_fs, input int exp_fcnt, input int exp_done,
                          input bit chk7);
        int c, apply7;
        bit got, en_early, en_drop, en_seen;
        model_run();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        c = 0; apply7 = -1; got = 0; en_early = 0; en_drop = 0; en_seen = 0;
        while (c < 8000) begin
            if (done) begin
                got = 1;
                break;
            end
            if (dut_enable && c <= HOLD) en_early = 1;
            if (dut_enable) en_seen = 1;
            else if (en_seen) en_drop = 1;
            if (step_idx == 4'd7 && apply7 < 0) apply7 = c;
            start = (c == 5);
            @(posedge clk); #1;
            c++;
        end
        start = 1'b0;
        chk({tag, " done_seen"}, int'(got), 1);
        chk({tag, " done_cycle"}, c, m_done_c);
        if (exp_done >= 0) chk({tag, " done_cycle_const"}, c, exp_done);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " pass"}, int'(pass), int'(exp_pass));
        chk({tag, " quiesce_fail"}, int'(quiesce_fail), int'(exp_qf));
        chk({tag, " fail_step"}, int'(fail_step), exp_fs);
        chk({tag, " dut_sw_held"}, int'(dut_sw), int'(m_last_sw));
        chk({tag, " enable_at_done"}, int'(dut_enable), 0);
        chk({tag, " enable_in_quiesce"}, int'(en_early), 0);
        chk({tag, " enable_dropped"}, int'(en_drop), 0);
`ifdef SELFTEST_CONTINUE_EN
        chk({tag, " fail_cnt"}, int'(fail_cnt), exp_fcnt);
`else
        if (chk7) chk({tag, " timeout_len"}, c - apply7, 1 + TMO);
`endif
        idle(12);
        chk({tag, " done_held"}, int'(done), 1);
    endtask

    task automatic load_pat(input int pat, input int bad_a, input int bad_b, input logic [1:0] m);
        for (int k = 0; k < NST; k++) begin
            if (pat == 1) begin
                cur_sw[k] = 2'b11; cur_exp[k] = 2'b10; cur_mask[k] = 2'b10;
            end else begin
                cur_sw[k]   = 2'(k % 3);
                cur_exp[k]  = (k == bad_a || k == bad_b) ? 2'b11 : 2'(k % 3);
                cur_mask[k] = m;
            end
        end
    endtask

    task automatic wait_idx(input logic [IW-1:0] idx);
        int n;
        n = 0;
        while (step_idx != idx && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_step_idx", int'(step_idx), int'(idx));
    endtask

    typedef struct {
        int pat; int delay; bit frc; logic [1:0] fval; int bad_a; int bad_b;
        logic [1:0] mask; bit exp_pass; bit exp_qf; int exp_fs; int exp_fcnt;
        int exp_done; bit chk7;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{0, 5, 1'b0, 2'b00, -1, -1, 2'b11, 1'b1, 1'b0,  0, 0, -1, 1'b0};
        vecs[1] = '{0, 0, 1'b0, 2'b00,  7, -1, 2'b11, 1'b0, 1'b0,  7, 1, -1, 1'b1};
        vecs[2] = '{0, 2, 1'b1, 2'b01, -1, -1, 2'b11, 1'b0, 1'b1,  0, 0,  1, 1'b0};
        vecs[3] = '{0, 3, 1'b0, 2'b00, 15, -1, 2'b11, 1'b0, 1'b0, 15, 1, -1, 1'b0};
        vecs[4] = '{0, 2, 1'b0, 2'b00, -1, -1, 2'b00, 1'b1, 1'b0,  0, 0, HOLD + 3*NST, 1'b0};
        vecs[5] = '{1, 4, 1'b0, 2'b00, -1, -1, 2'b10, 1'b1, 1'b0,  0, 0, -1, 1'b0};
        vecs[6] = '{0, 1, 1'b0, 2'b00,  2,  9, 2'b11, 1'b0, 1'b0,  2, 2, -1, 1'b0};
        vecs[7] = '{0, 4, 1'b0, 2'b00,  0, -1, 2'b11, 1'b0, 1'b0,  0, 1, -1, 1'b0};

        load_pat(0, -1, -1, 2'b11);
        rst_n = 1'b0;
        idle(10);
        chk("reset_outputs", int'({dut_enable, dut_sw, step_idx, busy, done, pass,
                                   quiesce_fail, fail_step}), 0);
`ifdef SELFTEST_CONTINUE_EN
        chk("reset_fail_cnt", int'(fail_cnt), 0);
`endif
        rst_n = 1'b1;
        idle(3);

        // Directed scenario table
        for (int v = 0; v < 8; v++) begin
            load_pat(vecs[v].pat, vecs[v].bad_a, vecs[v].bad_b, vecs[v].mask);
            cur_delay = vecs[v].delay;
            force_val = vecs[v].fval;
            force_on  = vecs[v].frc;
            idle(4);
            do_run($sformatf("vec%0d", v), vecs[v].exp_pass, vecs[v].exp_qf,
                   vecs[v].exp_fs, vecs[v].exp_fcnt, vecs[v].exp_done, vecs[v].chk7);
            force_on = 1'b0;
            idle(4);
        end

        // Randomized step tables scored against the model
        for (int r = 0; r < 6; r++) begin
            cur_delay = $urandom_range(0, 5);
            for (int k = 0; k < NST; k++) begin
                cur_sw[k]   = 2'($urandom_range(0, 3));
                cur_mask[k] = 2'($urandom_range(0, 3));
                cur_exp[k]  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : cur_sw[k];
            end
            model_run();
            do_run($sformatf("rnd%0d", r), m_pass, m_qfail, m_fail_step, m_fail_cnt, -1, 1'b0);
        end

        // Reset in the middle of a WAIT at step 3
        load_pat(0, -1, -1, 2'b11);
        cur_delay = 5;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_idx(4'd3);
        idle(2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", int'({dut_enable, dut_sw, step_idx, busy, done, pass,
                                         quiesce_fail, fail_step}), 0);
        idle(1);
        rst_n = 1'b1;
        idle(5);
        chk("after_reset_idle", int'({busy, done, dut_enable, step_idx}), 0);
        idle(8);

        // Abort and start together during WAIT: abort wins
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_idx(4'd3);
        idle(2);
        abort = 1'b1; start = 1'b1;
        @(posedge clk); #1 abort = 1'b0; start = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_enable", int'(dut_enable), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_pass", int'(pass), 0);
        idle(12);
        chk("abort_stays_idle", int'(busy), 0);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("restart_busy", int'(busy), 1);
        chk("restart_quiesce_enable", int'(dut_enable), 0);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        chk("abort_in_quiesce", int'(busy), 0);
        idle(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/smachine_selftest_seq.md
Name: smachine_selftest_seq

Overview:
- Synthesizable on-board self-test sequencer for the S-Machine CPU. It generalises the directed enable/switch/LED bring-up flow to parametrised switch and LED counts and a step table of any depth.
- Drives the CPU's enable and switch inputs and samples its LEDs.
- Walks an external step table of switch values, expected LEDs and masks.
- Reports pass/fail with a per-step timeout.
- Sits between the board I/O and the SMachine top; active only when a self-test is requested.

Parameters:
- NUM_SW, 2, width of switch vector driven to CPU
- NUM_LED, 2, width of LED vector sampled from CPU
- NUM_STEPS, 16, step-table depth (>=1)
- HOLD_CYCLES, 2, cycles enable is held low in the quiesce check (>=1)
- TIMEOUT, 200, max cycles waited per step for an LED match (>=1)
- IDX_W, $clog2(NUM_STEPS) (min 1), step index width

Ports:
- clk, in, 1, system clock, rising edge
- rst_n, in, 1, asynchronous active-low reset
- start, in, 1, single-cycle request; ignored while busy
- abort, in, 1, synchronous abort to IDLE
- dut_enable, out, 1, CPU enable
- dut_sw, out, NUM_SW, CPU switch inputs (registered)
- dut_led, in, NUM_LED, CPU LED outputs
- step_idx, out, IDX_W, table address; table answers combinationally in the same cycle
- step_sw, in, NUM_SW, switch value for the current step
- step_exp, in, NUM_LED, expected LED value
- step_mask, in, NUM_LED, LED compare mask (1 = checked)
- busy, out, 1, sequence in progress
- done, out, 1, sequence finished; held until next start
- pass, out, 1, valid when done
- quiesce_fail, out, 1, LEDs nonzero while enable low
- fail_step, out, IDX_W, first failing step index

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - All outputs 0: dut_enable, dut_sw, step_idx, busy, done, pass, quiesce_fail, fail_step.
  - Synchroniser and counters cleared.
- dut_led passes through a 2-flop synchroniser; all compares use led_s, which lags dut_led by 2 cycles.
- States: IDLE, QUIESCE, APPLY, WAIT, NEXT, DONE.
- IDLE:
  - dut_enable=0, busy=0.
  - On start: go to QUIESCE next cycle.
  - Clear done, pass, quiesce_fail, fail_step and step_idx; load hold counter = HOLD_CYCLES; busy=1 from the next cycle.
- QUIESCE:
  - dut_enable=0, dut_sw=0.
  - Any cycle with led_s != 0 sets quiesce_fail=1 and goes to DONE with pass=0.
  - When the counter expires, go to APPLY.
- APPLY (1 cycle):
  - Register dut_sw <= step_sw and set dut_enable=1.
  - Load timer = TIMEOUT; go to WAIT.
- WAIT:
  - Match = ((led_s ^ step_exp) & step_mask) == 0.
  - On match, go to NEXT.
  - Otherwise decrement the timer; at timer==1 with no match, record fail_step = step_idx and go to DONE, pass=0.
  - Match and timeout in the same cycle: match wins.
  - step_mask==0 matches in the first WAIT cycle.
- NEXT:
  - If step_idx == NUM_STEPS-1, go to DONE with pass = no failure recorded.
  - Else step_idx+1, then APPLY. No wrap-around.
- DONE:
  - dut_enable=0, busy=0, done=1.
  - dut_sw holds its last value.
  - start restarts from QUIESCE.
- dut_enable stays 1 across APPLY/WAIT/NEXT of consecutive steps; the CPU is not re-reset between steps.
- abort: from any busy state, go to IDLE next cycle; dut_enable=0, done=0, pass=0. abort with start in the same cycle: abort wins.
- start while busy: ignored. start in DONE: accepted.
- Minimum run length with every step matching immediately: 1 + HOLD_CYCLES + 3*NUM_STEPS cycles from start to done=1.

Optional Feature:
- Macro: SELFTEST_CONTINUE_EN.
- Defined:
  - A step timeout does not abort. fail_step latches the first failing index only.
  - Adds output fail_cnt [IDX_W:0], counting failed steps and saturating at NUM_STEPS.
  - The sequence always runs all steps; pass = (fail_cnt==0 && !quiesce_fail).
  - A quiesce failure still aborts.
- Undefined: abort on first failure; no fail_cnt port.

Decomposition:
- Package smachine_selftest_pkg holds:
  - state enum (IDLE..DONE)
  - synchroniser stage count constant (2)
- Natural sub-module: smachine_sync2, a parametrised-width 2-flop synchroniser with async active-low reset, used on dut_led.

Test Plan:
- Reset mid-WAIT at step 3: rst_n=0 -> next edge shows all outputs 0 and state IDLE; no start needed to stay idle.
- Quiesce fault: dut_led=2'b01 while enable low, start -> quiesce_fail=1, done=1, pass=0, dut_enable never 1.
- Full pass, NUM_STEPS=16, CPU model echoes dut_sw to LEDs after 5 cycles, step_exp=step_sw, mask=2'b11 -> done=1, pass=1, dut_enable continuously 1 from first APPLY to DONE.
- Timeout at step 7, expected never produced, TIMEOUT=200 -> fail_step=7, pass=0, done asserted exactly 200 WAIT cycles after entering step 7.
- Mask: step_mask=2'b10, led=2'b11, exp=2'b10 -> step passes; mask=0 step passes in one WAIT cycle.
- Abort and start together during WAIT -> IDLE next cycle, dut_enable=0, done=0; a later start in IDLE begins QUIESCE. With SELFTEST_CONTINUE_EN: steps 2 and 9 failing -> fail_step=2, fail_cnt=2, all 16 steps visited.
